// File: rtl/pc_fetch_pkg.sv
// Shared widths, constants and helpers for the instruction fetch stage.
package pc_fetch_pkg;

  localparam int WORD_W    = 32;
  localparam int J_INDEX_W = 26;

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP   = 32'd4;

  // Clear the byte-offset bits so the result is a word address.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: stall hold > jump > branch > sequential.
module pc_next_sel
  import pc_fetch_pkg::*;
(
  input  logic [WORD_W-1:0]    pc,
  input  logic                 stall,
  input  logic                 jump,
  input  logic [J_INDEX_W-1:0] jump_index,
  input  logic                 branch_taken,
  input  logic [WORD_W-1:0]    branch_target,
  output logic [WORD_W-1:0]    next_pc,
  output logic                 redirect,
  output logic                 misalign
);

  logic [WORD_W-1:0] pc_plus4;

  // Pick the next PC; a held cycle ignores redirects entirely.
  always_comb begin
    pc_plus4 = pc + PC_STEP;
    next_pc  = pc_plus4;
    redirect = 1'b0;
    misalign = 1'b0;
    if (stall) begin
      next_pc = pc;
    end else if (jump) begin
      next_pc  = {pc_plus4[WORD_W-1:WORD_W-4], jump_index, 2'b00};
      redirect = 1'b1;
    end else if (branch_taken) begin
      next_pc  = align_word(branch_target);
      redirect = 1'b1;
      misalign = |branch_target[1:0];
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register,
// accepted-instruction counter and sticky address-error flag.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          MEM_BYTES  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [WORD_W-1:0]    branch_target,
  input  logic                 jump,
  input  logic [J_INDEX_W-1:0] jump_index,
  output logic [WORD_W-1:0]    Address,
  input  logic [WORD_W-1:0]    Instruction,
  output logic [WORD_W-1:0]    if_id_instr,
  output logic [WORD_W-1:0]    if_id_pc_plus4,
  output logic                 if_id_valid,
  output logic [WORD_W-1:0]    fetch_count,
  output logic                 addr_err
);

  localparam logic [WORD_W-1:0] MEM_LIMIT = WORD_W'(MEM_BYTES);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] next_pc;
  logic              redirect;
  logic              misalign;

  // Memory sees the PC with no added latency.
  assign Address  = pc;
  assign pc_plus4 = pc + PC_STEP;

  pc_next_sel u_next_sel (
    .pc            (pc),
    .stall         (stall),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .misalign      (misalign)
  );

  // Advance PC, load or flush IF/ID, count accepted fetches, latch errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_ADDR;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= 32'h0000_0000;
      if_id_valid    <= 1'b0;
      fetch_count    <= 32'h0000_0000;
      addr_err       <= 1'b0;
    end else begin
      pc <= next_pc;
      if ((pc >= MEM_LIMIT) || misalign) begin
        addr_err <= 1'b1;
      end
      if (!stall) begin
        if_id_pc_plus4 <= pc_plus4;
        if (redirect) begin
          // The word fetched this cycle is on the wrong path: drop it.
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
        end else begin
          if_id_instr <= Instruction;
          if_id_valid <= 1'b1;
          fetch_count <= fetch_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios with literal
// expectations plus a randomized run, all compared against a cycle model.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        reset0, reset1;
  logic        stall, jump, branch_taken;
  logic [31:0] branch_target;
  logic [25:0] jump_index;

  logic [31:0] d_addr [2];
  logic [31:0] d_imem [2];
  logic [31:0] d_instr[2];
  logic [31:0] d_pc4  [2];
  logic        d_valid[2];
  logic [31:0] d_cnt  [2];
  logic        d_err  [2];

  int checks = 0;
  int errors = 0;

  // Model state per instance
  logic [31:0] m_pc   [2];
  logic [31:0] m_instr[2];
  logic [31:0] m_pc4  [2];
  logic        m_valid[2];
  logic [31:0] m_cnt  [2];
  logic        m_err  [2];
  logic [31:0] m_ra   [2];

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  assign d_imem[0] = imem(d_addr[0]);
  assign d_imem[1] = imem(d_addr[1]);

  pc_fetch #(.RESET_ADDR(32'h0000_0000), .MEM_BYTES(1024)) dut0 (
    .clk(clk), .reset(reset0), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .Address(d_addr[0]), .Instruction(d_imem[0]), .if_id_instr(d_instr[0]),
    .if_id_pc_plus4(d_pc4[0]), .if_id_valid(d_valid[0]),
    .fetch_count(d_cnt[0]), .addr_err(d_err[0]));

  pc_fetch #(.RESET_ADDR(32'h0000_03F8), .MEM_BYTES(1024)) dut1 (
    .clk(clk), .reset(reset1), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .Address(d_addr[1]), .Instruction(d_imem[1]), .if_id_instr(d_instr[1]),
    .if_id_pc_plus4(d_pc4[1]), .if_id_valid(d_valid[1]),
    .fetch_count(d_cnt[1]), .addr_err(d_err[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of the architectural behaviour of a fetch stage.
  task automatic model_step(input int i, input logic rst);
    logic [31:0] seq;
    seq = m_pc[i] + 32'd4;
    if (rst) begin
      m_pc[i] = m_ra[i]; m_instr[i] = 32'h0; m_pc4[i] = 32'h0;
      m_valid[i] = 1'b0; m_cnt[i] = 32'h0; m_err[i] = 1'b0;
    end else begin
      if (m_pc[i] >= 32'd1024) m_err[i] = 1'b1;
      if (stall) begin
        // everything holds
      end else if (jump || branch_taken) begin
        m_instr[i] = 32'h0;
        m_valid[i] = 1'b0;
        if (jump) begin
          m_pc[i] = {seq[31:28], jump_index, 2'b00};
        end else begin
          if (branch_target[1:0] != 2'b00) m_err[i] = 1'b1;
          m_pc[i] = branch_target & 32'hFFFF_FFFC;
        end
      end else begin
        m_instr[i] = imem(m_pc[i]);
        m_pc4[i]   = seq;
        m_valid[i] = 1'b1;
        m_cnt[i]   = m_cnt[i] + 32'd1;
        m_pc[i]    = seq;
      end
    end
  endtask

  // Advance one clock, update the model, then compare every output.
  task automatic tick();
    @(posedge clk);
    model_step(0, reset0);
    model_step(1, reset1);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("addr%0d", i), d_addr[i], m_pc[i]);
      chk($sformatf("valid%0d", i), {31'h0, d_valid[i]}, {31'h0, m_valid[i]});
      chk($sformatf("instr%0d", i), d_instr[i], m_instr[i]);
      chk($sformatf("count%0d", i), d_cnt[i], m_cnt[i]);
      chk($sformatf("err%0d", i), {31'h0, d_err[i]}, {31'h0, m_err[i]});
      if (m_valid[i]) chk($sformatf("pc4_%0d", i), d_pc4[i], m_pc4[i]);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; jump_index = 26'h0;
  endtask

  task automatic reset_dut0();
    reset0 = 1'b1; tick(); reset0 = 1'b0;
  endtask

  initial begin
    m_ra[0] = 32'h0000_0000;
    m_ra[1] = 32'h0000_03F8;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 32'h0; m_instr[i] = 32'h0; m_pc4[i] = 32'h0;
      m_valid[i] = 1'b0; m_cnt[i] = 32'h0; m_err[i] = 1'b0;
    end
    idle_inputs();
    reset0 = 1'b1; reset1 = 1'b1;
    @(negedge clk);

    // Reset values
    tick();
    chk("rst_addr", d_addr[0], 32'h0);
    chk("rst_addr1", d_addr[1], 32'h3F8);
    chk("rst_valid", {31'h0, d_valid[0]}, 32'h0);
    chk("rst_count", d_cnt[0], 32'h0);
    reset0 = 1'b0;

    // Free run: Address 4,8,...,28 and counter 7 on the eighth cycle
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("run_addr", d_addr[0], 32'(4 * k));
    end
    chk("run_count", d_cnt[0], 32'd7);
    chk("run_pc4", d_pc4[0], 32'd28);

    // Stall at 0x10 for three cycles
    reset_dut0();
    repeat (4) tick();
    chk("pre_stall_addr", d_addr[0], 32'h10);
    stall = 1'b1;
    jump = 1'b1; jump_index = 26'h3FF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_addr", d_addr[0], 32'h10);
      chk("stall_count", d_cnt[0], 32'd4);
      chk("stall_pc4", d_pc4[0], 32'h10);
    end
    idle_inputs();
    tick();
    chk("resume_addr", d_addr[0], 32'h14);
    chk("resume_count", d_cnt[0], 32'd5);

    // Branch from 0x08 to 0x40
    reset_dut0();
    repeat (2) tick();
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    chk("br_addr", d_addr[0], 32'h40);
    chk("br_flush", {31'h0, d_valid[0]}, 32'h0);
    chk("br_count", d_cnt[0], 32'd2);
    idle_inputs();
    tick();
    chk("br_valid", {31'h0, d_valid[0]}, 32'h1);
    chk("br_instr", d_instr[0], imem(32'h40));
    chk("br_pc4", d_pc4[0], 32'h44);

    // Jump beats branch at 0x20; then misaligned branch
    reset_dut0();
    repeat (8) tick();
    chk("pre_jump_addr", d_addr[0], 32'h20);
    jump = 1'b1; jump_index = 26'h10; branch_taken = 1'b1; branch_target = 32'h80;
    tick();
    chk("jmp_addr", d_addr[0], 32'h40);
    chk("jmp_count", d_cnt[0], 32'd8);
    jump = 1'b0; branch_target = 32'h41;
    tick();
    chk("mis_addr", d_addr[0], 32'h40);
    chk("mis_err", {31'h0, d_err[0]}, 32'h1);
    idle_inputs();

    // Reset wins over stall and jump at 0x30
    reset_dut0();
    repeat (12) tick();
    chk("pre_rst_addr", d_addr[0], 32'h30);
    reset0 = 1'b1; stall = 1'b1; jump = 1'b1; jump_index = 26'h55;
    tick();
    chk("rst2_addr", d_addr[0], 32'h0);
    chk("rst2_instr", d_instr[0], 32'h0);
    chk("rst2_pc4", d_pc4[0], 32'h0);
    chk("rst2_count", d_cnt[0], 32'h0);
    chk("rst2_err", {31'h0, d_err[0]}, 32'h0);
    reset0 = 1'b0;
    idle_inputs();

    // Free run across the end of memory from 0x3F8
    reset1 = 1'b1; tick(); reset1 = 1'b0;
    chk("end_addr0", d_addr[1], 32'h3F8);
    tick();
    tick();
    chk("end_addr2", d_addr[1], 32'h400);
    chk("end_err_pre", {31'h0, d_err[1]}, 32'h0);
    tick();
    chk("end_err", {31'h0, d_err[1]}, 32'h1);
    stall = 1'b1;
    repeat (3) tick();
    chk("end_err_sticky", {31'h0, d_err[1]}, 32'h1);
    stall = 1'b0;
    reset1 = 1'b1; tick(); reset1 = 1'b0;
    chk("end_err_clr", {31'h0, d_err[1]}, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int sel;
      reset0 = ($urandom_range(0, 49) == 0);
      reset1 = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 3) == 0);
      jump = ($urandom_range(0, 9) == 0);
      branch_taken = ($urandom_range(0, 6) == 0);
      jump_index = ($urandom_range(0, 3) == 0) ? 26'($urandom()) : 26'($urandom_range(0, 300));
      sel = $urandom_range(0, 9);
      if (sel < 6)       branch_target = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      else if (sel < 8)  branch_target = 32'($urandom_range(0, 1100));
      else if (sel == 8) branch_target = $urandom();
      else               branch_target = 32'hFFFF_FFFC;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter MEM_BYTES, default 1024, byte size of instruction memory addressed downstream.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold PC and IF/ID register this cycle.
REQ-006 branch_taken  input  1  redirect to branch_target.
REQ-007 branch_target  input  32  byte address of branch destination.
REQ-008 jump  input  1  redirect to jump target.
REQ-009 jump_index  input  26  J-format word index.
REQ-010 Address  output  32  current PC, drives InstructionMemory Address.
REQ-011 Instruction  input  32  word returned combinationally by InstructionMemory for Address.
REQ-012 if_id_instr  output  32  registered instruction for decode.
REQ-013 if_id_pc_plus4  output  32  registered PC+4 of that instruction.
REQ-014 if_id_valid  output  1  if_id_instr is a real fetched instruction.
REQ-015 fetch_count  output  32  number of instructions accepted into IF/ID.
REQ-016 addr_err  output  1  sticky: misaligned redirect or PC >= MEM_BYTES seen.

Function
REQ-017 Address SHALL equal the PC register combinationally; zero added latency to memory.
REQ-018 Next-PC priority SHALL be: reset > stall (hold) > jump > branch_taken > PC+4.
REQ-019 Jump target SHALL be {pc_plus4[31:28], jump_index, 2'b00}, pc_plus4 = PC+4 of current PC.
REQ-020 Branch target SHALL be branch_target with bits [1:0] forced to 0; nonzero [1:0] SHALL set addr_err.
REQ-021 PC+4 SHALL be 32-bit modulo; 32'hFFFF_FFFC wraps to 0 without error beyond REQ-022.
REQ-022 addr_err SHALL set on any cycle where PC >= MEM_BYTES and clear only on reset.
REQ-023 Normal cycle (no stall, no redirect): IF/ID loads Instruction and PC+4, if_id_valid=1, fetch_count increments by 1 (wraps mod 2^32).
REQ-024 Stall cycle: PC, IF/ID, fetch_count unchanged; jump/branch_taken ignored that cycle and must be reasserted.
REQ-025 Redirect cycle (jump or branch_taken, no stall): PC loads target; IF/ID loads if_id_instr=32'h0000_0000, if_id_valid=0 (flush wrong-path fetch); fetch_count unchanged.
REQ-026 jump and branch_taken together SHALL take jump target, one flush only.
REQ-027 After reset release, first valid IF/ID entry SHALL appear one cycle after the first non-stall cycle (fetch latency 1 cycle).

Reset
REQ-028 On reset: PC=RESET_ADDR, if_id_instr=0, if_id_pc_plus4=0, if_id_valid=0, fetch_count=0, addr_err=0.
REQ-029 Reset SHALL override stall and redirects in the same cycle; reset mid-stream discards IF/ID content.

Structure
REQ-030 Shared package pc_fetch_pkg SHALL hold WORD_W=32, J_INDEX_W=26, NOP_INSTR=32'h0000_0000, PC_STEP=4.
REQ-031 Next-PC selection SHALL be one combinational sub-module pc_next_sel (inputs PC, stall, jump, jump_index, branch_taken, branch_target; outputs next_pc, redirect, misalign).
REQ-032 pc_fetch SHALL hold only the PC, IF/ID, fetch_count and addr_err registers.

Verification
REQ-033 Reset then 8 free-running cycles -> Address 0,4,...,28; if_id_pc_plus4 lags by one cycle (4..28); fetch_count=7 at cycle 8.
REQ-034 Stall held 3 cycles at PC=0x10 -> Address stays 0x10, if_id_* and fetch_count frozen; resumes 0x14 after release.
REQ-035 branch_taken=1, branch_target=0x40 at PC=0x08 -> next Address 0x40, if_id_valid=0 one cycle, then instruction at 0x40 valid.
REQ-036 jump=1 with branch_taken=1, jump_index=26'h10, PC=0x20 -> Address 0x40 (jump wins); branch_target=0x41 alone -> Address 0x40, addr_err=1.
REQ-037 Free-run from RESET_ADDR=0x3F8, MEM_BYTES=1024 -> addr_err rises when Address=0x400; stays set until reset.
REQ-038 reset asserted together with stall and jump at PC=0x30 -> next cycle Address=RESET_ADDR, all outputs at reset values.
